// File: rtl/spike_codec_pkg.sv
// Shared definitions for the spike rate encoder and the matching accumulator side.
package spike_codec_pkg;

  localparam int unsigned DEFAULT_TIMER_WIDTH = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_e;

  // Window length in cycles for a given timer width.
  function automatic int unsigned w_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/spike_phase_acc.sv
// Phase accumulator: the carry-out of acc+val is the spike, so val spikes come out
// evenly spread over one full wrap of the accumulator.
module spike_phase_acc
  import spike_codec_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = DEFAULT_TIMER_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_load,
  input  logic                   i_step,
  input  logic [TIMER_WIDTH-1:0] i_val,
  output logic                   o_spike
);

  logic [TIMER_WIDTH-1:0] r_acc;
  logic [TIMER_WIDTH-1:0] r_val;
  logic                   r_spike;
  logic [TIMER_WIDTH:0]   w_sum;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_val};
  assign o_spike = r_spike;

  // A load on a step edge still emits the old window's last spike before clearing acc.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_acc   <= '0;
      r_val   <= '0;
      r_spike <= 1'b0;
    end else begin
      r_spike <= i_step ? w_sum[TIMER_WIDTH] : 1'b0;
      if (i_load) begin
        r_val <= i_val;
        r_acc <= '0;
      end else if (i_step) begin
        r_acc <= w_sum[TIMER_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes a count into exactly that many spikes over a 2^TIMER_WIDTH-cycle window.
// SPIKE_RATE_ENCODER_BACK_TO_BACK_EN allows reloading on the last window cycle.
module spike_rate_encoder
  import spike_codec_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = DEFAULT_TIMER_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TIMER_WIDTH-1:0] in_count,
  output logic                   spike,
  output logic                   busy,
  output logic                   window_done
);

  localparam int unsigned            W_LEN    = w_len(TIMER_WIDTH);
  localparam logic [TIMER_WIDTH-1:0] LAST_CNT = TIMER_WIDTH'(W_LEN - 1);

  enc_state_e             r_state;
  enc_state_e             w_state_nxt;
  logic [TIMER_WIDTH-1:0] r_cnt;
  logic [TIMER_WIDTH-1:0] w_cnt_nxt;
  logic                   r_window_done;
  logic                   w_done_nxt;
  logic                   w_load;
  logic                   w_step;
  logic                   w_last;
  logic                   w_ready;
  logic                   w_accept;

  assign w_last = (r_state == RUN) && (r_cnt == LAST_CNT);

`ifdef SPIKE_RATE_ENCODER_BACK_TO_BACK_EN
  assign w_ready = (r_state == IDLE) || w_last;
`else
  assign w_ready = (r_state == IDLE);
`endif

  assign w_accept    = in_valid && w_ready;
  assign in_ready    = w_ready;
  assign busy        = (r_state == RUN);
  assign window_done = r_window_done;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_window_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_window_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step    = 1'b1;
        w_cnt_nxt = r_cnt + TIMER_WIDTH'(1);
        if (w_last) begin
          w_done_nxt = 1'b1;
          // Only reachable with back-to-back reload; otherwise drop to IDLE.
          if (w_accept) begin
            w_load    = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  spike_phase_acc #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_phase_acc (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_load),
    .i_step (w_step),
    .i_val  (in_count),
    .o_spike(spike)
  );

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: a 3-bit instance checked against fixed patterns and
// a 5-bit instance checked by a window scoreboard.
module tb_spike_rate_encoder;

`ifdef SPIKE_RATE_ENCODER_BACK_TO_BACK_EN
  localparam int unsigned B2B_WAITS = 31;
`else
  localparam int unsigned B2B_WAITS = 32;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn3, in_valid3, in_ready3, spike3, busy3, done3;
  logic [2:0] in_count3;
  logic       rstn5, in_valid5, in_ready5, spike5, busy5, done5;
  logic [4:0] in_count5;

  spike_rate_encoder #(.TIMER_WIDTH(3)) dut3 (
    .clk(clk), .rstn(rstn3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_count(in_count3), .spike(spike3), .busy(busy3), .window_done(done3)
  );

  spike_rate_encoder #(.TIMER_WIDTH(5)) dut5 (
    .clk(clk), .rstn(rstn5), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_count(in_count5), .spike(spike5), .busy(busy5), .window_done(done5)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Closed-form Bresenham: step j spikes when floor(j*v/W) advances.
  function automatic logic [31:0] model_pat(input int unsigned v, input int unsigned tw);
    logic [31:0] p;
    int unsigned w;
    p = '0;
    w = 32'd1 << tw;
    for (int unsigned j = 1; j <= w; j++)
      p[w-j] = (((j * v) >> tw) != (((j - 1) * v) >> tw));
    return p;
  endfunction

  typedef struct {
    int unsigned val;
    logic [31:0] pat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned mon_cnt     = 0;
  int unsigned spike_total = 0;
  logic [31:0] mon_hist    = '0;
  logic        prev_done   = 1'b0;

  // Window monitor for the 5-bit instance.
  always @(negedge clk) begin
    if (!rstn5) begin
      mon_cnt   = 0;
      mon_hist  = '0;
      prev_done = 1'b0;
    end else begin
      mon_hist = {mon_hist[30:0], spike5};
      if (spike5) begin
        mon_cnt++;
        spike_total++;
        if (sb.size() > 0) chk("spike_bound", 32'(mon_cnt > sb[0].val), 32'd0);
      end
      if (done5) begin
        chk("done_pulse", 32'(prev_done), 32'd0);
        chk("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("win_count", mon_cnt, mon_e.val);
          chk("win_pattern", mon_hist, mon_e.pat);
        end
        mon_cnt = 0;
      end
      prev_done = done5;
    end
  end

  task automatic send5(input int unsigned v, output int unsigned waits);
    exp_t e;
    waits     = 0;
    in_valid5 = 1'b1;
    in_count5 = 5'(v);
    while (!in_ready5 && waits < 200) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("accept_timeout", 32'(in_ready5), 32'd1);
    if (in_ready5) begin
      e.val = v;
      e.pat = model_pat(v, 5);
      sb.push_back(e);
      @(posedge clk); #1;
    end
    in_valid5 = 1'b0;
  endtask

  task automatic drain5();
    int unsigned n = 0;
    while ((sb.size() > 0 || busy5) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb.size() == 0 && !busy5), 32'd1);
  endtask

  task automatic run3(input logic [2:0] v, input logic [7:0] exp_pat);
    logic [7:0] pat;
    logic [7:0] dpat;
    chk("dut3_ready_idle", 32'(in_ready3), 32'd1);
    in_valid3 = 1'b1;
    in_count3 = v;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    chk("dut3_busy_run", 32'(busy3), 32'd1);
    chk("dut3_ready_run", 32'(in_ready3), 32'd0);
    chk("dut3_spike_first", 32'(spike3), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      pat[7-i]  = spike3;
      dpat[7-i] = done3;
    end
    chk("dut3_pattern", 32'(pat), 32'(exp_pat));
    chk("dut3_done_pos", 32'(dpat), 32'h01);
    chk("dut3_busy_end", 32'(busy3), 32'd0);
    chk("dut3_ready_end", 32'(in_ready3), 32'd1);
    @(posedge clk); #1;
    chk("dut3_spike_after", 32'(spike3), 32'd0);
    chk("dut3_done_after", 32'(done3), 32'd0);
  endtask

  typedef struct {
    logic [2:0] cnt;
    logic [7:0] pat;
  } vec3_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec3_t       tbl3[6];
    int unsigned w;
    int unsigned base;

    tbl3[0] = '{cnt: 3'd3, pat: 8'b0010_0101};
    tbl3[1] = '{cnt: 3'd0, pat: 8'b0000_0000};
    tbl3[2] = '{cnt: 3'd7, pat: 8'b0111_1111};
    tbl3[3] = '{cnt: 3'd1, pat: 8'b0000_0001};
    tbl3[4] = '{cnt: 3'd4, pat: 8'b0101_0101};
    tbl3[5] = '{cnt: 3'd5, pat: 8'b0101_1011};

    rstn3 = 1'b0; in_valid3 = 1'b0; in_count3 = '0;
    rstn5 = 1'b0; in_valid5 = 1'b0; in_count5 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst3_spike", 32'(spike3), 32'd0);
    chk("rst3_busy", 32'(busy3), 32'd0);
    chk("rst3_done", 32'(done3), 32'd0);
    chk("rst3_ready", 32'(in_ready3), 32'd1);
    chk("rst5_spike", 32'(spike5), 32'd0);
    chk("rst5_busy", 32'(busy5), 32'd0);
    chk("rst5_done", 32'(done5), 32'd0);
    chk("rst5_ready", 32'(in_ready5), 32'd1);
    rstn3 = 1'b1;
    rstn5 = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run3(tbl3[i].cnt, tbl3[i].pat);

    for (int unsigned v = 0; v < 32; v++) begin
      send5(v, w);
      drain5();
    end

    // Held valid with a second value during RUN: accept only once ready returns.
    base = spike_total;
    send5(5, w);
    send5(9, w);
    chk("b2b_waits", w, B2B_WAITS);
    drain5();
    chk("b2b_spikes", spike_total - base, 32'd14);

    // Reset mid-window at cnt=10 with val=20.
    send5(20, w);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rstn5 = 1'b0;
    @(posedge clk); #1;
    rstn5 = 1'b1;
    sb.delete();
    chk("abort_spike", 32'(spike5), 32'd0);
    chk("abort_busy", 32'(busy5), 32'd0);
    chk("abort_done", 32'(done5), 32'd0);
    chk("abort_ready", 32'(in_ready5), 32'd1);
    base = spike_total;
    send5(4, w);
    drain5();
    chk("abort_reload_spikes", spike_total - base, 32'd4);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Converts a TIMER_WIDTH-bit count into a rate-coded spike train: exactly in_count spikes spread evenly over a fixed window of 2^TIMER_WIDTH cycles.
- Acts as the transmit-side inverse of the spike accumulator. A spike counter that is reset at window start and runs for the whole window recovers in_count exactly.
- Sits between the host/weight-load logic and the SNN array inputs.

Parameters:
- TIMER_WIDTH, 5: width of the count and of the window timer. Window length is W_LEN = 2^TIMER_WIDTH cycles.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_count is valid.
- in_ready  output  1  encoder accepts a count this cycle.
- in_count  input  TIMER_WIDTH  spikes to emit in the window, 0..W_LEN-1.
- spike  output  1  registered spike output, one bit per cycle.
- busy  output  1  window in progress (state RUN).
- window_done  output  1  one-cycle pulse on the final window cycle.

Behaviour:
- Reset: on a clk edge with rstn=0, the block goes to IDLE. spike=0, window_done=0, busy=0, phase acc=0, cycle cnt=0, latched value=0. Reset mid-window aborts immediately with no further spikes.
- States: IDLE and RUN.
- In IDLE, in_ready=1.
- Accept: an edge with in_valid && in_ready latches val<=in_count, acc<=0, cnt<=0, and moves to RUN.
- In RUN, on each edge:
  - sum = {1'b0,acc} + {1'b0,val} (TIMER_WIDTH+1 bits)
  - spike<=sum[TIMER_WIDTH]
  - acc<=sum[TIMER_WIDTH-1:0]
  - cnt<=cnt+1
- When cnt==W_LEN-1 on a RUN edge: window_done<=1 and state<=IDLE (unless reloaded, see Optional Feature).
- Timing:
  - spike is valid for exactly W_LEN consecutive cycles, starting the cycle after the first RUN edge.
  - window_done is high in the same cycle as the last spike value.
  - In all other cycles spike=0.
- Spike count per window is exactly val.
  - val=0: no spikes.
  - val=W_LEN-1: spikes in every cycle except the first.
- Spacing between spikes is floor or ceil of W_LEN/val (Bresenham).
- busy=1 exactly while state=RUN.
- Handshake rules:
  - in_count is sampled only on accept.
  - in_valid while not ready is ignored. The source must hold in_valid and in_count stable until accept.
  - in_ready never depends combinationally on in_valid.
- Arithmetic wraps modulo 2^TIMER_WIDTH for acc and cnt. No saturation is needed because in_count < W_LEN.

Optional Feature:
- Macro: SPIKE_RATE_ENCODER_BACK_TO_BACK_EN.
- Defined:
  - in_ready is also 1 in RUN when cnt==W_LEN-1.
  - An accept on that edge relatches val, clears acc and cnt, stays in RUN, and still pulses window_done.
  - The next window's spikes follow the current window's with zero idle cycles.
- Undefined:
  - in_ready=0 throughout RUN.
  - At least one IDLE cycle (spike=0) separates windows.

Decomposition:
- Shared package spike_codec_pkg holds:
  - the state enum (IDLE, RUN)
  - a function w_len(TIMER_WIDTH) returning 2^TIMER_WIDTH
  - a default TIMER_WIDTH constant shared with the accumulator side
- One natural sub-module is spike_phase_acc: the acc register, adder and carry-out spike, with load/step/clear controls. The FSM, cycle counter and handshake stay in the top module.

Test Plan:
- TIMER_WIDTH=3, load 3 at cycle k: spike pattern over the 8 cycles from k+2 is 0,0,1,0,0,1,0,1. window_done is high at cycle k+9, busy drops after it, and in_ready returns.
- TIMER_WIDTH=3, load 0: 8 cycles of spike=0, window_done pulses once. Load 7: pattern 0,1,1,1,1,1,1,1.
- Default width, sweep in_count 0..31, each window fed into accumulator_element (rstn pulsed at window start): accumulated_spikes equals in_count every time.
- Hold in_valid=1 with new values during RUN: no accept until ready. Without the macro there is exactly one idle cycle between windows. With SPIKE_RATE_ENCODER_BACK_TO_BACK_EN, two windows of 5 then 9 give 14 spikes over 64 contiguous cycles with no gap.
- Assert rstn=0 for one cycle mid-window (cnt=10, val=20): the next cycle has spike=0, busy=0, window_done=0, in_ready=1. A fresh load of 4 then yields exactly 4 spikes.
- Check that window_done is only ever a single-cycle pulse, and that the spike total never exceeds val in any window.
